// File: rtl/mct_axi_mem_responder.sv
// AXI4 slave memory responder: serves read bursts from and absorbs write bursts into
// an on-chip line array. One outstanding burst per direction, channels independent.
module mct_axi_mem_responder #(
    parameter int unsigned              C_ADDR_WIDTH = 64,
    parameter int unsigned              C_DATA_WIDTH = 512,
    parameter int unsigned              C_DEPTH_LOG2 = 10,
    parameter logic [C_ADDR_WIDTH-1:0]  C_BASE_ADDR  = '0
) (
    input  logic                        ap_clk,
    input  logic                        ap_rst_n,
    input  logic                        s_axi_arvalid,
    output logic                        s_axi_arready,
    input  logic [C_ADDR_WIDTH-1:0]     s_axi_araddr,
    input  logic [7:0]                  s_axi_arlen,
    output logic                        s_axi_rvalid,
    input  logic                        s_axi_rready,
    output logic [C_DATA_WIDTH-1:0]     s_axi_rdata,
    output logic                        s_axi_rlast,
    input  logic                        s_axi_awvalid,
    output logic                        s_axi_awready,
    input  logic [C_ADDR_WIDTH-1:0]     s_axi_awaddr,
    input  logic [7:0]                  s_axi_awlen,
    input  logic                        s_axi_wvalid,
    output logic                        s_axi_wready,
    input  logic [C_DATA_WIDTH-1:0]     s_axi_wdata,
    input  logic [C_DATA_WIDTH/8-1:0]   s_axi_wstrb,
    input  logic                        s_axi_wlast,
    output logic                        s_axi_bvalid,
    input  logic                        s_axi_bready,
    output logic                        err_wlast,
    output logic [31:0]                 rd_beats,
    output logic [31:0]                 wr_beats
);
    localparam int unsigned STRB_W     = C_DATA_WIDTH / 8;
    localparam int unsigned IDX_W      = C_DEPTH_LOG2;
    localparam int unsigned DEPTH      = 1 << C_DEPTH_LOG2;
    localparam int unsigned LINE_SHIFT = 6;

    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_BURST} r_state_e;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP}   w_state_e;

    logic [C_DATA_WIDTH-1:0] mem [DEPTH];

    r_state_e                r_state_q, r_state_d;
    logic [IDX_W-1:0]        r_idx_q, r_idx_d;
    logic [7:0]              r_len_q, r_len_d, r_beat_q, r_beat_d;
    logic [C_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                    arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
    logic [31:0]             rd_beats_q, rd_beats_d;

    w_state_e                w_state_q, w_state_d;
    logic [IDX_W-1:0]        w_idx_q, w_idx_d;
    logic [7:0]              w_len_q, w_len_d, w_beat_q, w_beat_d;
    logic                    awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
    logic                    err_q, err_d;
    logic [31:0]             wr_beats_q, wr_beats_d;
    logic                    mem_we_c;

    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rlast   = rlast_q;
    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign err_wlast     = err_q;
    assign rd_beats      = rd_beats_q;
    assign wr_beats      = wr_beats_q;

    // Read channel: the next line is fetched on the same edge as each handshake, so no bubbles.
    always_comb begin
        r_state_d  = r_state_q;
        r_idx_d    = r_idx_q;
        r_len_d    = r_len_q;
        r_beat_d   = r_beat_q;
        rdata_d    = rdata_q;
        rd_beats_d = rd_beats_q;
        unique case (r_state_q)
            R_IDLE: begin
                if (s_axi_arvalid) begin
                    r_idx_d   = IDX_W'((s_axi_araddr - C_BASE_ADDR) >> LINE_SHIFT);
                    r_len_d   = s_axi_arlen;
                    r_beat_d  = '0;
                    r_state_d = R_FETCH;
                end
            end
            R_FETCH: begin
                rdata_d   = mem[r_idx_q];
                r_state_d = R_BURST;
            end
            R_BURST: begin
                if (s_axi_rready) begin
                    rd_beats_d = rd_beats_q + 32'd1;
                    r_beat_d   = r_beat_q + 8'd1;
                    r_idx_d    = r_idx_q + IDX_W'(1);
                    rdata_d    = mem[r_idx_d];
                    if (r_beat_q == r_len_q) begin
                        r_state_d = R_IDLE;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        arready_d = (r_state_d == R_IDLE);
        rvalid_d  = (r_state_d == R_BURST);
        rlast_d   = (r_state_d == R_BURST) && (r_beat_d == r_len_d);
    end

    // Write channel: the awlen beat count ends the burst; wlast is only cross-checked.
    always_comb begin
        w_state_d  = w_state_q;
        w_idx_d    = w_idx_q;
        w_len_d    = w_len_q;
        w_beat_d   = w_beat_q;
        err_d      = err_q;
        wr_beats_d = wr_beats_q;
        mem_we_c   = 1'b0;
        unique case (w_state_q)
            W_IDLE: begin
                if (s_axi_awvalid) begin
                    w_idx_d   = IDX_W'((s_axi_awaddr - C_BASE_ADDR) >> LINE_SHIFT);
                    w_len_d   = s_axi_awlen;
                    w_beat_d  = '0;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (s_axi_wvalid) begin
                    mem_we_c   = 1'b1;
                    wr_beats_d = wr_beats_q + 32'd1;
                    w_beat_d   = w_beat_q + 8'd1;
                    w_idx_d    = w_idx_q + IDX_W'(1);
                    if (s_axi_wlast != (w_beat_q == w_len_q)) begin
                        err_d = 1'b1;
                    end
                    if (w_beat_q == w_len_q) begin
                        w_state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (s_axi_bready) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
        awready_d = (w_state_d == W_IDLE);
        wready_d  = (w_state_d == W_DATA);
        bvalid_d  = (w_state_d == W_RESP);
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state_q  <= R_IDLE;
            r_idx_q    <= '0;
            r_len_q    <= '0;
            r_beat_q   <= '0;
            rdata_q    <= '0;
            arready_q  <= 1'b1;
            rvalid_q   <= 1'b0;
            rlast_q    <= 1'b0;
            rd_beats_q <= '0;
            w_state_q  <= W_IDLE;
            w_idx_q    <= '0;
            w_len_q    <= '0;
            w_beat_q   <= '0;
            awready_q  <= 1'b1;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            err_q      <= 1'b0;
            wr_beats_q <= '0;
        end else begin
            r_state_q  <= r_state_d;
            r_idx_q    <= r_idx_d;
            r_len_q    <= r_len_d;
            r_beat_q   <= r_beat_d;
            rdata_q    <= rdata_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rlast_q    <= rlast_d;
            rd_beats_q <= rd_beats_d;
            w_state_q  <= w_state_d;
            w_idx_q    <= w_idx_d;
            w_len_q    <= w_len_d;
            w_beat_q   <= w_beat_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            err_q      <= err_d;
            wr_beats_q <= wr_beats_d;
        end
    end

    // Line array is deliberately left unreset; byte lanes gated by wstrb.
    always_ff @(posedge ap_clk) begin
        if (mem_we_c) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (s_axi_wstrb[i]) begin
                    mem[w_idx_q][i*8 +: 8] <= s_axi_wdata[i*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_mct_axi_mem_responder.sv
// Randomized self-checking bench for mct_axi_mem_responder against a line-array model.
module tb_mct_axi_mem_responder;
    localparam int DEPTH = 1024;

    logic         ap_clk = 1'b0;
    logic         ap_rst_n = 1'b0;
    logic         s_axi_arvalid = 1'b0, s_axi_arready;
    logic [63:0]  s_axi_araddr = '0;
    logic [7:0]   s_axi_arlen = '0;
    logic         s_axi_rvalid, s_axi_rready = 1'b0;
    logic [511:0] s_axi_rdata;
    logic         s_axi_rlast;
    logic         s_axi_awvalid = 1'b0, s_axi_awready;
    logic [63:0]  s_axi_awaddr = '0;
    logic [7:0]   s_axi_awlen = '0;
    logic         s_axi_wvalid = 1'b0, s_axi_wready;
    logic [511:0] s_axi_wdata = '0;
    logic [63:0]  s_axi_wstrb = '0;
    logic         s_axi_wlast = 1'b0;
    logic         s_axi_bvalid, s_axi_bready = 1'b0;
    logic         err_wlast;
    logic [31:0]  rd_beats, wr_beats;

    logic [511:0] model [DEPTH];
    int           errors = 0;
    int           checks = 0;
    logic [31:0]  exp_rd = '0;
    logic [31:0]  exp_wr = '0;
    logic         exp_err = 1'b0;

    always #5 ap_clk = ~ap_clk;

    mct_axi_mem_responder dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rlast(s_axi_rlast),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .err_wlast(err_wlast), .rd_beats(rd_beats), .wr_beats(wr_beats)
    );

    function automatic logic [511:0] rand_line();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Write burst; early_beat >= 0 raises wlast too soon, drop_last withholds it on the final beat.
    task automatic do_write(input int line, input int len, input bit data_is_k,
                            input logic [63:0] strb, input int early_beat, input bit drop_last);
        logic [511:0] d;
        int n;
        int idx;
        s_axi_awaddr  = 64'(line) * 64'd64 + 64'($urandom_range(0, 63));
        s_axi_awlen   = 8'(len);
        s_axi_awvalid = 1'b1;
        n = 0;
        while (s_axi_awready !== 1'b1 && n < 50) begin @(posedge ap_clk); #1; n++; end
        checks++;
        if (s_axi_awready !== 1'b1) begin
            errors++; $display("FAIL aw_timeout awready=%b required 1", s_axi_awready); return;
        end
        @(posedge ap_clk); #1;
        s_axi_awvalid = 1'b0;
        checks++;
        if (s_axi_awready !== 1'b0) begin
            errors++; $display("FAIL awready_busy awready=%b required 0", s_axi_awready);
        end
        for (int k = 0; k <= len; k++) begin
            if ($urandom_range(0, 3) == 0) begin s_axi_wvalid = 1'b0; @(posedge ap_clk); #1; end
            d = data_is_k ? 512'(k) : rand_line();
            s_axi_wvalid = 1'b1;
            s_axi_wdata  = d;
            s_axi_wstrb  = strb;
            s_axi_wlast  = (k == len) ? !drop_last : (k == early_beat);
            n = 0;
            while (s_axi_wready !== 1'b1 && n < 50) begin @(posedge ap_clk); #1; n++; end
            checks++;
            if (s_axi_wready !== 1'b1) begin
                errors++; $display("FAIL w_timeout beat=%0d wready=%b required 1", k, s_axi_wready);
                s_axi_wvalid = 1'b0; return;
            end
            @(posedge ap_clk); #1;
            idx = (line + k) % DEPTH;
            for (int b = 0; b < 64; b++) if (strb[b]) model[idx][b*8 +: 8] = d[b*8 +: 8];
            if (s_axi_wlast != (k == len)) exp_err = 1'b1;
            exp_wr = exp_wr + 32'd1;
        end
        s_axi_wvalid = 1'b0;
        s_axi_wlast  = 1'b0;
        n = $urandom_range(0, 3);
        for (int c = 0; c <= n; c++) begin
            checks++;
            if (s_axi_bvalid !== 1'b1) begin
                errors++; $display("FAIL bvalid_hold cycle=%0d bvalid=%b required 1", c, s_axi_bvalid);
            end
            if (c < n) begin @(posedge ap_clk); #1; end
        end
        s_axi_bready = 1'b1;
        @(posedge ap_clk); #1;
        s_axi_bready = 1'b0;
        checks++;
        if (s_axi_bvalid !== 1'b0 || s_axi_awready !== 1'b1) begin
            errors++; $display("FAIL b_done bvalid=%b awready=%b required 0/1", s_axi_bvalid, s_axi_awready);
        end
        checks++;
        if (err_wlast !== exp_err) begin
            errors++; $display("FAIL err_wlast got=%b required %b", err_wlast, exp_err);
        end
        checks++;
        if (wr_beats !== exp_wr) begin
            errors++; $display("FAIL wr_beats got=%0d required %0d", wr_beats, exp_wr);
        end
    endtask

    // Read burst with rready dropped stall_pct percent of cycles; checks every valid cycle.
    task automatic do_read(input int line, input int len, input int stall_pct);
        int n;
        int k;
        int cyc;
        s_axi_araddr  = 64'(line) * 64'd64 + 64'($urandom_range(0, 63));
        s_axi_arlen   = 8'(len);
        s_axi_arvalid = 1'b1;
        s_axi_rready  = 1'b0;
        n = 0;
        while (s_axi_arready !== 1'b1 && n < 50) begin @(posedge ap_clk); #1; n++; end
        checks++;
        if (s_axi_arready !== 1'b1) begin
            errors++; $display("FAIL ar_timeout arready=%b required 1", s_axi_arready); return;
        end
        @(posedge ap_clk); #1;
        s_axi_arvalid = 1'b0;
        checks++;
        if (s_axi_arready !== 1'b0 || s_axi_rvalid !== 1'b0) begin
            errors++; $display("FAIL r_fetch arready=%b rvalid=%b required 0/0", s_axi_arready, s_axi_rvalid);
        end
        @(posedge ap_clk); #1;
        k = 0;
        cyc = 0;
        while (k <= len && cyc < 4 * len + 100) begin
            s_axi_rready = ($urandom_range(0, 99) >= stall_pct);
            #3;
            checks++;
            if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== model[(line + k) % DEPTH] || s_axi_rlast !== (k == len)) begin
                errors++;
                $display("FAIL r_beat beat=%0d rvalid=%b rlast=%b rdata=%h required rlast=%b rdata=%h",
                         k, s_axi_rvalid, s_axi_rlast, s_axi_rdata, (k == len), model[(line + k) % DEPTH]);
            end
            if (s_axi_rready && s_axi_rvalid === 1'b1) begin k++; exp_rd = exp_rd + 32'd1; end
            @(posedge ap_clk); #1;
            cyc++;
        end
        s_axi_rready = 1'b0;
        checks++;
        if (k <= len) begin
            errors++; $display("FAIL r_timeout beats=%0d required %0d", k, len + 1);
        end
        checks++;
        if (s_axi_rvalid !== 1'b0 || s_axi_arready !== 1'b1) begin
            errors++; $display("FAIL r_done rvalid=%b arready=%b required 0/1", s_axi_rvalid, s_axi_arready);
        end
        checks++;
        if (rd_beats !== exp_rd) begin
            errors++; $display("FAIL rd_beats got=%0d required %0d", rd_beats, exp_rd);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (s_axi_arready !== 1'b1 || s_axi_awready !== 1'b1 || s_axi_rvalid !== 1'b0 ||
            s_axi_rlast !== 1'b0 || s_axi_wready !== 1'b0 || s_axi_bvalid !== 1'b0 || err_wlast !== 1'b0) begin
            errors++;
            $display("FAIL %s_ctrl ar=%b aw=%b rv=%b rl=%b wr=%b bv=%b err=%b required 1 1 0 0 0 0 0", tag,
                     s_axi_arready, s_axi_awready, s_axi_rvalid, s_axi_rlast, s_axi_wready, s_axi_bvalid, err_wlast);
        end
        checks++;
        if (rd_beats !== 32'd0 || wr_beats !== 32'd0 || s_axi_rdata !== 512'd0) begin
            errors++; $display("FAIL %s_data rd=%0d wr=%0d rdata_nonzero=%b required 0 0 0", tag,
                               rd_beats, wr_beats, (s_axi_rdata != 512'd0));
        end
    endtask

    task automatic test_reset();
        ap_rst_n = 1'b0;
        repeat (2) @(posedge ap_clk);
        #1;
        check_reset_outputs("reset");
        ap_rst_n = 1'b1;
        @(posedge ap_clk); #1;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) do_write(i * 256, 255, 1'b0, '1, -1, 1'b0);
    endtask

    task automatic test_write_read_basic();
        do_write(1, 3, 1'b1, '1, -1, 1'b0);
        do_read(1, 3, 0);
    endtask

    task automatic test_single_beat();
        do_read(5, 0, 0);
    endtask

    task automatic test_backpressure();
        do_read($urandom_range(0, DEPTH - 1), 255, 40);
    endtask

    task automatic test_partial_strb();
        do_write(10, 0, 1'b0, 64'h0000_0000_0000_000F, -1, 1'b0);
        do_read(10, 0, 20);
    endtask

    task automatic test_wrap();
        do_read(1023, 1, 0);
        do_write(1022, 3, 1'b0, '1, -1, 1'b0);
        do_read(1021, 5, 30);
    endtask

    task automatic test_wlast_missing();
        do_write(20, 3, 1'b0, '1, -1, 1'b1);
        do_read(20, 3, 0);
    endtask

    // Asynchronous reset in the middle of a long read burst.
    task automatic test_reset_mid_read();
        int n;
        s_axi_araddr  = 64'd40 * 64'd64;
        s_axi_arlen   = 8'd255;
        s_axi_arvalid = 1'b1;
        n = 0;
        while (s_axi_arready !== 1'b1 && n < 50) begin @(posedge ap_clk); #1; n++; end
        @(posedge ap_clk); #1;
        s_axi_arvalid = 1'b0;
        s_axi_rready  = 1'b1;
        repeat (4) @(posedge ap_clk);
        #3;
        ap_rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        s_axi_rready = 1'b0;
        exp_rd  = '0;
        exp_wr  = '0;
        exp_err = 1'b0;
        @(posedge ap_clk); #1;
        ap_rst_n = 1'b1;
        @(posedge ap_clk); #1;
        do_read(40, 7, 10);
    endtask

    task automatic test_wlast_early();
        do_write(30, 3, 1'b0, '1, 1, 1'b0);
        do_read(30, 3, 0);
    endtask

    task automatic test_concurrent();
        fork
            do_read(300, 15, 30);
            do_write(600, 15, 1'b0, '1, -1, 1'b0);
        join
        do_read(600, 15, 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fill();
        test_write_read_basic();
        test_single_beat();
        test_backpressure();
        test_partial_strb();
        test_wrap();
        test_wlast_missing();
        test_reset_mid_read();
        test_wlast_early();
        test_concurrent();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
